// File: rtl/dino_obstacle_engine_if.sv
// Bus between the dino obstacle engine and the game FSM / LCD top level.
// The master side (game FSM) drives the key and state, the slave side
// (the engine) returns the track, the jump status and the event pulses.
interface dino_obstacle_engine_if;
   logic        key_jump;
   logic [1:0]  game_state;
   logic [15:0] obstacle_map;
   logic        dino_air;
   logic [3:0]  blocks_passed;
   logic        collision_detected;
   logic        game_clear;

   modport master (
      output key_jump, game_state,
      input  obstacle_map, dino_air, blocks_passed, collision_detected, game_clear
   );

   modport slave (
      input  key_jump, game_state,
      output obstacle_map, dino_air, blocks_passed, collision_detected, game_clear
   );
endinterface

// File: rtl/dino_obstacle_engine.sv
// Dino game engine: scrolls a 16-column obstacle track, spawns obstacles
// from an 8-bit LFSR, times the dino jump and reports collision / clear
// as single-cycle pulses. Work happens only while game_state is 2'b01.
module dino_obstacle_engine #(
   parameter int unsigned TICK_CYC    = 200,
   parameter int unsigned JUMP_TICKS  = 3,
   parameter int unsigned CLEAR_COUNT = 10,
   parameter int unsigned DINO_COL    = 1,
   parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
   input  logic                   clk_1khz,
   input  logic                   rst,
   dino_obstacle_engine_if.slave  bus
);

   localparam int unsigned TW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
   localparam int unsigned AW = (JUMP_TICKS > 0) ? $clog2(JUMP_TICKS + 1) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYC - 1);
   localparam logic [AW-1:0] JUMP_LOAD = AW'(JUMP_TICKS);
   localparam logic [3:0]    CLEAR_TGT = 4'(CLEAR_COUNT);

   logic [1:0]    sync_q,    sync_d;
   logic [7:0]    lfsr_q,    lfsr_d;
   logic [15:0]   map_q,     map_d;
   logic [AW-1:0] air_q,     air_d;
   logic          dair_q,    dair_d;
   logic [3:0]    passed_q,  passed_d;
   logic          coll_q,    coll_d;
   logic          clr_q,     clr_d;
   logic [TW-1:0] tick_q,    tick_d;
   logic [3:0]    spawned_q, spawned_d;
   logic [1:0]    gap_q,     gap_d;
   logic          halt_q,    halt_d;

   logic running_s;
   logic rise_s;
   logic tick_s;
   logic spawn_s;
   logic hit_s;

   // Next-state logic for the whole engine; defaults hold every register.
   always_comb begin
      // LFSR x^8+x^6+x^5+x^4+1 free-runs in every game state
      lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      sync_d    = {sync_q[0], bus.key_jump};
      running_s = (bus.game_state == 2'b01);
      rise_s    = (sync_q == 2'b01);
      tick_s    = (tick_q == TICK_LAST);
      spawn_s   = (lfsr_q[1:0] == 2'b00) && (gap_q >= 2'd2) && (spawned_q < CLEAR_TGT);
      hit_s     = 1'b0;

      map_d     = map_q;
      air_d     = air_q;
      passed_d  = passed_q;
      tick_d    = tick_q;
      spawned_d = spawned_q;
      gap_d     = gap_q;
      halt_d    = halt_q;
      coll_d    = 1'b0;
      clr_d     = 1'b0;

      if (!running_s) begin
         map_d     = 16'h0000;
         air_d     = '0;
         passed_d  = 4'd0;
         tick_d    = '0;
         spawned_d = 4'd0;
         gap_d     = 2'd0;
         halt_d    = 1'b0;
      end else if (halt_q) begin
         // frozen until the FSM leaves the running state
         halt_d    = 1'b1;
      end else begin
         tick_d = tick_s ? '0 : tick_q + TW'(1'b1);

         // a new jump wins over the tick decrement in the same cycle
         if (rise_s && (air_q == '0)) begin
            air_d = JUMP_LOAD;
         end else if (tick_s && (air_q != '0)) begin
            air_d = air_q - AW'(1'b1);
         end else begin
            air_d = air_q;
         end

         if (tick_s) begin
            map_d     = {spawn_s, map_q[15:1]};
            gap_d     = spawn_s ? 2'd0 : ((gap_q == 2'd3) ? 2'd3 : gap_q + 2'd1);
            spawned_d = spawned_q + {3'd0, spawn_s};
            passed_d  = passed_q + {3'd0, map_q[0]};
            // judged on the values the player will see after this tick
            hit_s     = map_d[DINO_COL] && (air_d == '0);
            if (hit_s) begin
               coll_d = 1'b1;
               halt_d = 1'b1;
            end else if (passed_d == CLEAR_TGT) begin
               clr_d  = 1'b1;
               halt_d = 1'b1;
            end else begin
               halt_d = 1'b0;
            end
         end else begin
            hit_s = 1'b0;
         end
      end

      dair_d = (air_d != '0);
   end

   // State register with synchronous active-high reset.
   always_ff @(posedge clk_1khz) begin
      if (rst) begin
         sync_q    <= 2'b00;
         lfsr_q    <= LFSR_SEED;
         map_q     <= 16'h0000;
         air_q     <= '0;
         dair_q    <= 1'b0;
         passed_q  <= 4'd0;
         coll_q    <= 1'b0;
         clr_q     <= 1'b0;
         tick_q    <= '0;
         spawned_q <= 4'd0;
         gap_q     <= 2'd0;
         halt_q    <= 1'b0;
      end else begin
         sync_q    <= sync_d;
         lfsr_q    <= lfsr_d;
         map_q     <= map_d;
         air_q     <= air_d;
         dair_q    <= dair_d;
         passed_q  <= passed_d;
         coll_q    <= coll_d;
         clr_q     <= clr_d;
         tick_q    <= tick_d;
         spawned_q <= spawned_d;
         gap_q     <= gap_d;
         halt_q    <= halt_d;
      end
   end

   assign bus.obstacle_map       = map_q;
   assign bus.dino_air           = dair_q;
   assign bus.blocks_passed      = passed_q;
   assign bus.collision_detected = coll_q;
   assign bus.game_clear         = clr_q;

endmodule

// File: tb/tb_dino_obstacle_engine.sv
// Self-checking bench for dino_obstacle_engine: a cycle model predicts every
// output, expectations are queued at drive time and compared after each edge;
// a scenario table drives the jump / collision / win cases.
module tb_dino_obstacle_engine;

   localparam int         TC   = 4;
   localparam int         JT   = 3;
   localparam int         CC   = 2;
   localparam int         DC   = 1;
   localparam logic [7:0] SEED = 8'hA5;

   typedef struct packed {
      logic [7:0]  lfsr;
      logic [1:0]  sync;
      logic [15:0] map;
      logic [3:0]  air;
      logic        dair;
      logic [3:0]  passed;
      logic        coll;
      logic        clr;
      logic [9:0]  tick;
      logic [3:0]  spawned;
      logic [1:0]  gap;
      logic        halt;
   } mst_t;

   typedef struct packed {
      logic [15:0] map;
      logic        dair;
      logic [3:0]  passed;
      logic        coll;
      logic        clr;
      logic [7:0]  lfsr;
   } obs_t;

   typedef struct {
      string name;
      int    press_k;     // press when the next arrival is this many cycles away (0 = never)
      bit    press_all;   // jump for every obstacle, not just the first
      int    exp_coll;
      int    exp_clr;
      int    exp_passed;
      bit    exp_empty;   // track must be empty once halted
   } scen_t;

   logic clk_1khz;
   logic rst;
   dino_obstacle_engine_if ifc();

   dino_obstacle_engine #(
      .TICK_CYC(TC), .JUMP_TICKS(JT), .CLEAR_COUNT(CC), .DINO_COL(DC), .LFSR_SEED(SEED)
   ) dut (
      .clk_1khz(clk_1khz),
      .rst     (rst),
      .bus     (ifc)
   );

   initial clk_1khz = 1'b0;
   always #5 clk_1khz = ~clk_1khz;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   coll_seen = 0;
   int   clr_seen  = 0;
   mst_t mdl;
   obs_t sb_q[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      else n_pass++;
   endtask

   // Reference behaviour of one clock edge.
   function automatic mst_t mstep(mst_t s, logic key, logic [1:0] gs, logic r);
      mst_t n;
      logic spn;
      n = s;
      if (r) begin
         n = '0;
         n.lfsr = SEED;
         return n;
      end
      n.lfsr = {s.lfsr[6:0], s.lfsr[7] ^ s.lfsr[5] ^ s.lfsr[4] ^ s.lfsr[3]};
      n.sync = {s.sync[0], key};
      n.coll = 1'b0;
      n.clr  = 1'b0;
      if (gs != 2'b01) begin
         n.map = '0; n.air = '0; n.dair = 1'b0; n.passed = '0;
         n.tick = '0; n.spawned = '0; n.gap = '0; n.halt = 1'b0;
         return n;
      end
      if (s.halt) return n;
      n.tick = (s.tick == 10'(TC - 1)) ? 10'd0 : s.tick + 10'd1;
      if (s.sync == 2'b01 && s.air == 4'd0) n.air = 4'(JT);
      else if (s.tick == 10'(TC - 1) && s.air != 4'd0) n.air = s.air - 4'd1;
      if (s.tick == 10'(TC - 1)) begin
         spn = (s.lfsr[1:0] == 2'b00) && (s.gap >= 2'd2) && (int'(s.spawned) < CC);
         n.map     = {spn, s.map[15:1]};
         n.gap     = spn ? 2'd0 : ((s.gap == 2'd3) ? 2'd3 : s.gap + 2'd1);
         n.spawned = s.spawned + 4'(spn);
         n.passed  = s.passed + 4'(s.map[0]);
         if (n.map[DC] && n.air == 4'd0) begin
            n.coll = 1'b1; n.halt = 1'b1;
         end else if (int'(n.passed) == CC) begin
            n.clr = 1'b1; n.halt = 1'b1;
         end
      end
      n.dair = (n.air != 4'd0);
      return n;
   endfunction

   // Cycles until the tick that brings an obstacle into the dino column (-1 if none soon).
   function automatic int arrival_in(mst_t s);
      mst_t n;
      for (int k = 0; k < 600; k++) begin
         n = mstep(s, 1'b0, 2'b01, 1'b0);
         if (!s.halt && s.tick == 10'(TC - 1) && n.map[DC]) return k;
         if (n.halt) return -1;
         s = n;
      end
      return -1;
   endfunction

   task automatic drive(input logic r, input logic [1:0] gs, input logic key);
      obs_t e;
      @(negedge clk_1khz);
      rst            = r;
      ifc.game_state = gs;
      ifc.key_jump   = key;
      mdl = mstep(mdl, key, gs, r);
      e = '{map: mdl.map, dair: mdl.dair, passed: mdl.passed,
            coll: mdl.coll, clr: mdl.clr, lfsr: mdl.lfsr};
      sb_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk_1khz);
      #2;
   endtask

   // Scoreboard: compare each queued expectation just after its edge.
   always @(posedge clk_1khz) begin
      obs_t e;
      obs_t a;
      #1;
      if (sb_q.size() != 0) begin
         e = sb_q.pop_front();
         a = '{map: ifc.obstacle_map, dair: ifc.dino_air, passed: ifc.blocks_passed,
               coll: ifc.collision_detected, clr: ifc.game_clear, lfsr: dut.lfsr_q};
         check("cycle_outputs", 32'(a), 32'(e));
         if (ifc.collision_detected === 1'b1) coll_seen++;
         if (ifc.game_clear === 1'b1) clr_seen++;
      end
   end

   initial begin
      scen_t sc[4];
      int    k;
      int    hold;
      bit    pressed;
      logic  kv;

      sc[0] = '{"no_jump",    0,          1'b0, 1, 0, 0, 1'b0};
      sc[1] = '{"timed_jump", TC + 1,     1'b0, 1, 0, 1, 1'b0};
      sc[2] = '{"early_jump", 4 * TC + 1, 1'b0, 1, 0, 0, 1'b0};
      sc[3] = '{"win",        TC,         1'b1, 0, 1, 2, 1'b1};

      mdl = '0;
      rst = 1'b1;
      ifc.key_jump   = 1'b0;
      ifc.game_state = 2'b00;

      // reset held 3 cycles while the inputs try to start a game
      repeat (3) drive(1'b1, 2'b01, 1'b1);
      settle();
      check("reset_map",    32'(ifc.obstacle_map), 32'h0);
      check("reset_flags",  {28'd0, ifc.dino_air, ifc.collision_detected, ifc.game_clear, 1'b0}, 32'h0);
      check("reset_passed", 32'(ifc.blocks_passed), 32'h0);
      check("reset_lfsr",   32'(dut.lfsr_q), 32'h000000A5);

      for (int i = 0; i < 4; i++) begin
         // restart: one cycle out of the running state
         drive(1'b0, 2'b00, 1'b0);
         settle();
         check({sc[i].name, "_restart_map"},    32'(ifc.obstacle_map), 32'h0);
         check({sc[i].name, "_restart_passed"}, 32'(ifc.blocks_passed), 32'h0);
         check({sc[i].name, "_restart_lfsr"},   32'(dut.lfsr_q), 32'(mdl.lfsr));
         coll_seen = 0;
         clr_seen  = 0;
         hold      = 0;
         pressed   = 1'b0;
         for (int c = 0; c < 2000 && !mdl.halt; c++) begin
            k = arrival_in(mdl);
            if (hold > 0) begin
               kv = 1'b1;
               hold--;
            end else if (sc[i].press_k > 0 && k == sc[i].press_k &&
                         (sc[i].press_all || !pressed) && mdl.air == 4'd0) begin
               kv = 1'b1;
               hold = 1;
               pressed = 1'b1;
            end else begin
               kv = 1'b0;
            end
            drive(1'b0, 2'b01, kv);
         end
         // halted: everything frozen, keys ignored
         for (int c = 0; c < 100; c++) drive(1'b0, 2'b01, c[3]);
         settle();
         check({sc[i].name, "_collisions"}, 32'(coll_seen), 32'(sc[i].exp_coll));
         check({sc[i].name, "_clears"},     32'(clr_seen),  32'(sc[i].exp_clr));
         check({sc[i].name, "_passed"},     32'(ifc.blocks_passed), 32'(sc[i].exp_passed));
         if (sc[i].exp_empty) check({sc[i].name, "_track_empty"}, 32'(ifc.obstacle_map), 32'h0);
      end

      // reset in the middle of a run
      drive(1'b0, 2'b00, 1'b0);
      repeat (30) drive(1'b0, 2'b01, 1'b0);
      drive(1'b1, 2'b01, 1'b0);
      settle();
      check("midrun_reset_map",  32'(ifc.obstacle_map), 32'h0);
      check("midrun_reset_lfsr", 32'(dut.lfsr_q), 32'h000000A5);
      drive(1'b0, 2'b01, 1'b0);
      settle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
